gate_truth_checker: RTL

- Self-checking response end of the gate test path: drives every input combination into a combinational gate under test, waits a settle interval, samples the gate's output and compares it against a truth table given as a parameter.
- Reports mismatch count, first failing vector and a pass/done summary.
- Replaces manual waveform inspection of gate exercises (NOR, NAND, XOR, ...) with an on-chip, synthesizable checker usable on the board.

---
 rtl/gate_truth_checker.sv | 128 ++++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// Sweeps every input combination into a combinational gate under test and checks its output
// against the TRUTH table. Define GATE_CHK_SYNC_EN to pass dut_y through a 2-flop synchronizer.
module gate_truth_checker #(
    parameter int                   N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0] TRUTH  = 4'b0001,
    parameter int                   SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int SETTLE_MIN = (SETTLE < 1) ? 1 : SETTLE;
`ifdef GATE_CHK_SYNC_EN
    // Two extra hold cycles cover the synchronizer latency.
    localparam int HOLD = SETTLE_MIN + 2;
`else
    localparam int HOLD = SETTLE_MIN;
`endif
    localparam int              CNT_W    = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_IN-1:0]   vec_q;
    logic              busy_q;
    logic              done_q;
    logic [N_IN:0]     err_q;
    logic [N_IN-1:0]   ffv_q;
    logic              ffvalid_q;
    logic              y_cmp;

`ifdef GATE_CHK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], dut_y};
        end
    end

    assign y_cmp = sync_q[1];
`else
    assign y_cmp = dut_y;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            vec_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state.
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        err_q     <= '0;
                        ffv_q     <= '0;
                        ffvalid_q <= 1'b0;
                        done_q    <= 1'b0;
                        vec_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (y_cmp != TRUTH[vec_q]) begin
                        err_q <= err_q + (N_IN+1)'(1);
                        if (!ffvalid_q) begin
                            ffv_q     <= vec_q;
                            ffvalid_q <= 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        vec_q   <= vec_q + N_IN'(1);
                        cnt_q   <= '0;
                        state_q <= ST_SETTLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dut_in           = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    // done is cleared on start, so pass can never be seen while busy.
    assign pass             = done_q && (err_q == '0);
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule
